sram_uart_tx_interface: RTL and testbench

SRAM_UART_TX_INTERFACE -- requirements
Module: sram_uart_tx_interface

---
 rtl/sram_uart_tx_interface_if.sv | 27 ++
 rtl/sram_uart_tx_interface.sv | 122 ++++++++++++
 tb/tb_sram_uart_tx_interface.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_uart_tx_interface_if.sv
// Start/status handshake, SRAM read port and serial line
// of the SRAM-to-UART transmitter.
interface sram_uart_tx_interface_if;
  logic        Start;
  logic [17:0] Start_address;
  logic [17:0] Word_count;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, Start_address, Word_count,
    output SRAM_read_data,
    input  SRAM_address, SRAM_we_n,
    input  UART_TX_O, Busy, Done
  );

  modport slave (
    input  Start, Start_address, Word_count,
    input  SRAM_read_data,
    output SRAM_address, SRAM_we_n,
    output UART_TX_O, Busy, Done
  );
endinterface

// File: rtl/sram_uart_tx_interface.sv
// Streams a block of 16-bit SRAM words out of an 8N1 UART,
// high byte first, reading the SRAM with a 2-cycle latency.
module sram_uart_tx_interface #(
  parameter int CLOCKS_PER_BIT = 434
) (
  input logic                      Clock,
  input logic                      Reset,
  sram_uart_tx_interface_if.slave  sif
);
  localparam int TW =
    (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_ADDR,
    S_TX_WAIT,
    S_TX_CAPTURE,
    S_TX_FRAME,
    S_TX_DONE
  } tx_state_t;

  tx_state_t     state;
  logic [TW-1:0] bit_tmr;
  logic [3:0]    bit_idx;
  logic          byte_sel;
  logic [17:0]   words_left;
  logic [15:0]   word;
  logic [17:0]   addr;
  logic          tx;
  logic          busy;
  logic          done;
  logic [7:0]    cur_byte;
  logic          bit_nxt;

  // bit_idx 0 is the start bit; the value queued for slot
  // bit_idx+1 is data bit bit_idx, or the stop bit after bit 7
  always_comb begin
    cur_byte = byte_sel ? word[7:0] : word[15:8];
    bit_nxt  = 1'b1;
    if (bit_idx < 4'd8)
      bit_nxt = cur_byte[bit_idx[2:0]];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_TX_IDLE;
      bit_tmr    <= '0;
      bit_idx    <= '0;
      byte_sel   <= 1'b0;
      words_left <= '0;
      word       <= '0;
      addr       <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_TX_IDLE: begin
          if (sif.Start) begin
            if (sif.Word_count != 18'd0) begin
              addr       <= sif.Start_address;
              words_left <= sif.Word_count;
              busy       <= 1'b1;
              state      <= S_TX_ADDR;
            end else begin
              done  <= 1'b1;
              state <= S_TX_DONE;
            end
          end
        end
        S_TX_ADDR: state <= S_TX_WAIT;
        S_TX_WAIT: state <= S_TX_CAPTURE;
        S_TX_CAPTURE: begin
          word     <= sif.SRAM_read_data;
          tx       <= 1'b0;
          bit_tmr  <= '0;
          bit_idx  <= '0;
          byte_sel <= 1'b0;
          state    <= S_TX_FRAME;
        end
        S_TX_FRAME: begin
          if (bit_tmr != T_LAST) begin
            bit_tmr <= bit_tmr + TW'(1);
          end else begin
            bit_tmr <= '0;
            if (bit_idx != 4'd9) begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= bit_nxt;
            end else if (!byte_sel) begin
              // low byte follows the high stop bit directly
              byte_sel <= 1'b1;
              bit_idx  <= '0;
              tx       <= 1'b0;
            end else begin
              words_left <= words_left - 18'd1;
              if (words_left == 18'd1) begin
                done  <= 1'b1;
                state <= S_TX_DONE;
              end else begin
                addr  <= addr + 18'd1;
                state <= S_TX_ADDR;
              end
            end
          end
        end
        S_TX_DONE: begin
          busy  <= 1'b0;
          state <= S_TX_IDLE;
        end
        default: state <= S_TX_IDLE;
      endcase
    end
  end

  assign sif.SRAM_address = addr;
  assign sif.SRAM_we_n    = 1'b1;
  assign sif.UART_TX_O    = tx;
  assign sif.Busy         = busy;
  assign sif.Done         = done;
endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Directed bench: 2-cycle SRAM model, per-cycle line log
// and an 8N1 frame decoder.
module tb_sram_uart_tx_interface;
  localparam int CPB = 4;
  localparam int OFS = 1;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   log_en = 1'b0;
  bit   to;

  logic [15:0] d1, d2;
  logic        tx_q[$];
  logic        done_q[$];
  logic        busy_q[$];
  logic [17:0] addr_q[$];
  logic [7:0]  dec_b[$];
  int          dec_st[$];
  int          dec_ferr;
  logic [17:0] addr_seq[$];

  sram_uart_tx_interface_if sif();

  sram_uart_tx_interface #(.CLOCKS_PER_BIT(CPB)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .sif  (sif.slave)
  );

  always #5 Clock = ~Clock;

  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    case (a)
      18'h00010: return 16'hA55A;
      18'h00100: return 16'h1234;
      18'h00101: return 16'hABCD;
      18'h00102: return 16'h00FF;
      18'h3FFFF: return 16'hC3E1;
      18'h00000: return 16'h7E81;
      default:   return a[15:0] ^ 16'h5555;
    endcase
  endfunction

  always @(posedge Clock) begin
    d1 <= mem_rd(sif.SRAM_address);
    d2 <= d1;
  end
  assign sif.SRAM_read_data = d2;

  always @(negedge Clock) begin
    if (log_en) begin
      tx_q.push_back(sif.UART_TX_O);
      done_q.push_back(sif.Done);
      busy_q.push_back(sif.Busy);
      addr_q.push_back(sif.SRAM_address);
    end
  end

  task automatic clr_log();
    tx_q.delete();
    done_q.delete();
    busy_q.delete();
    addr_q.delete();
  endtask

  // log index 0 is the cycle Start is held; index 1 the first
  // cycle after the DUT samples it
  task automatic pulse_start(input logic [17:0] a,
                             input logic [17:0] n);
    @(posedge Clock); #1;
    sif.Start = 1'b1;
    sif.Start_address = a;
    sif.Word_count = n;
    clr_log();
    log_en = 1'b1;
    @(posedge Clock); #1;
    sif.Start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit t);
    t = 1'b1;
    for (int n = 0; n < max; n++) begin
      @(negedge Clock);
      if (sif.Done === 1'b1) begin
        t = 1'b0;
        break;
      end
    end
  endtask

  function automatic int first_done();
    foreach (done_q[i]) if (done_q[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int n_done();
    int c = 0;
    foreach (done_q[i]) if (done_q[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int n_low();
    int c = 0;
    foreach (tx_q[i]) if (tx_q[i] !== 1'b1) c++;
    return c;
  endfunction

  task automatic decode();
    int i;
    logic [7:0] v;
    dec_b.delete();
    dec_st.delete();
    dec_ferr = 0;
    i = 0;
    while (i < tx_q.size()) begin
      if (tx_q[i] !== 1'b0) begin
        i++;
      end else if (i + 10*CPB > tx_q.size()) begin
        dec_ferr++;
        i = tx_q.size();
      end else begin
        for (int k = 0; k < 10*CPB; k++)
          if (tx_q[i+k] !== tx_q[i+(k/CPB)*CPB]) dec_ferr++;
        if (tx_q[i+9*CPB] !== 1'b1) dec_ferr++;
        for (int k = 0; k < 8; k++) v[k] = tx_q[i+(k+1)*CPB];
        dec_b.push_back(v);
        dec_st.push_back(i);
        i += 10*CPB;
      end
    end
  endtask

  task automatic mk_seq();
    addr_seq.delete();
    foreach (addr_q[i])
      if (busy_q[i] === 1'b1 &&
          (addr_seq.size() == 0 || addr_seq[$] !== addr_q[i]))
        addr_seq.push_back(addr_q[i]);
  endtask

  task automatic test_reset();
    sif.Start = 1'b1;
    sif.Start_address = 18'h00010;
    sif.Word_count = 18'd1;
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    sif.Start = 1'b0;
    @(negedge Clock);
    tests++;
    if (sif.Busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy got %b want 0", sif.Busy);
    end
    tests++;
    if (sif.Done !== 1'b0) begin
      fails++;
      $display("FAIL rst_done got %b want 0", sif.Done);
    end
    tests++;
    if (sif.UART_TX_O !== 1'b1) begin
      fails++;
      $display("FAIL rst_tx got %b want 1", sif.UART_TX_O);
    end
    tests++;
    if (sif.SRAM_address !== 18'h0) begin
      fails++;
      $display("FAIL rst_addr got %h want 0", sif.SRAM_address);
    end
    tests++;
    if (sif.SRAM_we_n !== 1'b1) begin
      fails++;
      $display("FAIL rst_we_n got %b want 1", sif.SRAM_we_n);
    end
    clr_log();
    log_en = 1'b1;
    repeat (30) @(negedge Clock);
    log_en = 1'b0;
    tests++;
    if (n_low() != 0) begin
      fails++;
      $display("FAIL rst_start_ignored low=%0d want 0", n_low());
    end
  endtask

  task automatic test_single();
    int fd;
    pulse_start(18'h00010, 18'd1);
    wait_done(200, to);
    repeat (4) @(negedge Clock);
    log_en = 1'b0;
    decode();
    fd = first_done();
    tests++;
    if (to) begin
      fails++;
      $display("FAIL single_timeout got 1 want 0");
    end
    tests++;
    if (busy_q[OFS] !== 1'b1) begin
      fails++;
      $display("FAIL single_busy got %b want 1", busy_q[OFS]);
    end
    tests++;
    if (dec_ferr != 0 || dec_b.size() != 2) begin
      fails++;
      $display("FAIL single_frames got %0d/%0d want 2/0",
               dec_b.size(), dec_ferr);
    end else begin
      tests++;
      if (dec_b[0] !== 8'hA5 || dec_b[1] !== 8'h5A) begin
        fails++;
        $display("FAIL single_bytes got %h %h want a5 5a",
                 dec_b[0], dec_b[1]);
      end
      tests++;
      if (dec_st[0] != OFS + 3) begin
        fails++;
        $display("FAIL single_latency got %0d want %0d",
                 dec_st[0], OFS + 3);
      end
      tests++;
      if (fd - dec_st[0] != 20*CPB) begin
        fails++;
        $display("FAIL single_duration got %0d want %0d",
                 fd - dec_st[0], 20*CPB);
      end
    end
    tests++;
    if (n_done() != 1) begin
      fails++;
      $display("FAIL single_done_cnt got %0d want 1", n_done());
    end
    tests++;
    if (sif.Busy !== 1'b0) begin
      fails++;
      $display("FAIL single_busy_end got %b want 0", sif.Busy);
    end
  endtask

  task automatic test_multi();
    logic [7:0]  exp_b[6] = '{8'h12, 8'h34, 8'hAB,
                              8'hCD, 8'h00, 8'hFF};
    logic [17:0] exp_a[3] = '{18'h00100, 18'h00101, 18'h00102};
    pulse_start(18'h00100, 18'd3);
    wait_done(400, to);
    repeat (4) @(negedge Clock);
    log_en = 1'b0;
    decode();
    mk_seq();
    tests++;
    if (to || dec_ferr != 0 || dec_b.size() != 6) begin
      fails++;
      $display("FAIL multi_frames got %0d/%0d/%b want 6/0/0",
               dec_b.size(), dec_ferr, to);
    end else begin
      for (int k = 0; k < 6; k++) begin
        tests++;
        if (dec_b[k] !== exp_b[k]) begin
          fails++;
          $display("FAIL multi_byte%0d got %h want %h",
                   k, dec_b[k], exp_b[k]);
        end
      end
      tests++;
      if (dec_st[2] - dec_st[1] - 10*CPB != 3 ||
          dec_st[4] - dec_st[3] - 10*CPB != 3) begin
        fails++;
        $display("FAIL multi_gap got %0d %0d want 3 3",
                 dec_st[2] - dec_st[1] - 10*CPB,
                 dec_st[4] - dec_st[3] - 10*CPB);
      end
      tests++;
      if (dec_st[1] - dec_st[0] != 10*CPB) begin
        fails++;
        $display("FAIL multi_byte_gap got %0d want %0d",
                 dec_st[1] - dec_st[0], 10*CPB);
      end
    end
    tests++;
    if (addr_seq.size() != 3) begin
      fails++;
      $display("FAIL multi_addr_len got %0d want 3",
               addr_seq.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (addr_seq[k] !== exp_a[k]) begin
          fails++;
          $display("FAIL multi_addr%0d got %h want %h",
                   k, addr_seq[k], exp_a[k]);
        end
      end
    end
    tests++;
    if (n_done() != 1) begin
      fails++;
      $display("FAIL multi_done_cnt got %0d want 1", n_done());
    end
  endtask

  task automatic test_zero();
    logic [17:0] pre;
    int bad;
    int nb;
    pre = sif.SRAM_address;
    pulse_start(18'h00200, 18'd0);
    wait_done(10, to);
    repeat (20) @(negedge Clock);
    log_en = 1'b0;
    bad = 0;
    nb = 0;
    foreach (addr_q[i]) if (addr_q[i] !== pre) bad++;
    foreach (busy_q[i]) if (busy_q[i] !== 1'b0) nb++;
    tests++;
    if (to || first_done() != OFS) begin
      fails++;
      $display("FAIL zero_done_at got %0d want %0d",
               first_done(), OFS);
    end
    tests++;
    if (n_done() != 1) begin
      fails++;
      $display("FAIL zero_done_cnt got %0d want 1", n_done());
    end
    tests++;
    if (n_low() != 0) begin
      fails++;
      $display("FAIL zero_tx_low got %0d want 0", n_low());
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL zero_addr got %0d changes want 0", bad);
    end
    tests++;
    if (nb != 0) begin
      fails++;
      $display("FAIL zero_busy got %0d cycles want 0", nb);
    end
  endtask

  task automatic test_ignore();
    pulse_start(18'h00010, 18'd1);
    repeat (20) @(negedge Clock);
    @(posedge Clock); #1;
    sif.Start = 1'b1;
    sif.Start_address = 18'h00100;
    sif.Word_count = 18'd3;
    @(posedge Clock); #1;
    sif.Start = 1'b0;
    wait_done(200, to);
    sif.Start = 1'b1;
    @(posedge Clock); #1;
    sif.Start = 1'b0;
    repeat (60) @(negedge Clock);
    log_en = 1'b0;
    decode();
    tests++;
    if (to || dec_ferr != 0 || dec_b.size() != 2) begin
      fails++;
      $display("FAIL ignore_frames got %0d/%0d/%b want 2/0/0",
               dec_b.size(), dec_ferr, to);
    end else begin
      tests++;
      if (dec_b[0] !== 8'hA5 || dec_b[1] !== 8'h5A) begin
        fails++;
        $display("FAIL ignore_bytes got %h %h want a5 5a",
                 dec_b[0], dec_b[1]);
      end
    end
    tests++;
    if (n_done() != 1) begin
      fails++;
      $display("FAIL ignore_done_cnt got %0d want 1", n_done());
    end
    tests++;
    if (sif.Busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_busy got %b want 0", sif.Busy);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(18'h00010, 18'd1);
    repeat (24) @(negedge Clock);
    tests++;
    if (sif.UART_TX_O !== 1'b0) begin
      fails++;
      $display("FAIL mid_bit4 got %b want 0", sif.UART_TX_O);
    end
    Reset = 1'b1;
    @(negedge Clock);
    tests++;
    if (sif.UART_TX_O !== 1'b1 || sif.Busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset tx/busy got %b/%b want 1/0",
               sif.UART_TX_O, sif.Busy);
    end
    Reset = 1'b0;
    clr_log();
    repeat (40) @(negedge Clock);
    tests++;
    if (n_low() != 0) begin
      fails++;
      $display("FAIL mid_truncate low=%0d want 0", n_low());
    end
    pulse_start(18'h00010, 18'd1);
    wait_done(200, to);
    repeat (4) @(negedge Clock);
    log_en = 1'b0;
    decode();
    tests++;
    if (to || dec_ferr != 0 || dec_b.size() != 2) begin
      fails++;
      $display("FAIL mid_frames got %0d/%0d/%b want 2/0/0",
               dec_b.size(), dec_ferr, to);
    end else begin
      tests++;
      if (dec_b[0] !== 8'hA5 || dec_b[1] !== 8'h5A ||
          dec_st[0] != OFS + 3) begin
        fails++;
        $display("FAIL mid_resend got %h %h @%0d want a5 5a @%0d",
                 dec_b[0], dec_b[1], dec_st[0], OFS + 3);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b[4] = '{8'hC3, 8'hE1, 8'h7E, 8'h81};
    pulse_start(18'h3FFFF, 18'd2);
    wait_done(300, to);
    repeat (4) @(negedge Clock);
    log_en = 1'b0;
    decode();
    mk_seq();
    tests++;
    if (to || dec_ferr != 0 || dec_b.size() != 4) begin
      fails++;
      $display("FAIL wrap_frames got %0d/%0d/%b want 4/0/0",
               dec_b.size(), dec_ferr, to);
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (dec_b[k] !== exp_b[k]) begin
          fails++;
          $display("FAIL wrap_byte%0d got %h want %h",
                   k, dec_b[k], exp_b[k]);
        end
      end
    end
    tests++;
    if (addr_seq.size() != 2) begin
      fails++;
      $display("FAIL wrap_addr_len got %0d want 2",
               addr_seq.size());
    end else begin
      tests++;
      if (addr_seq[0] !== 18'h3FFFF || addr_seq[1] !== 18'h0) begin
        fails++;
        $display("FAIL wrap_addr got %h %h want 3ffff 00000",
                 addr_seq[0], addr_seq[1]);
      end
    end
    tests++;
    if (n_done() != 1) begin
      fails++;
      $display("FAIL wrap_done_cnt got %0d want 1", n_done());
    end
  endtask

  initial begin
    sif.Start = 1'b0;
    sif.Start_address = '0;
    sif.Word_count = '0;
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_ignore();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
